// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a unified memory port with a req/ready handshake.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       EQ,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUctrl,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECR    = 4'd6;
  localparam logic [3:0] EXECI    = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] TRAP     = 4'd10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state;
  logic [3:0] state_n;
  logic [2:0] alu_dec;
  logic       f3_ok;
  logic       br_ok;

  always_comb begin
    alu_dec = ALU_ADD;
    f3_ok   = 1'b1;
    unique case (1'b1)
      funct3 == 3'b000:
        alu_dec = (op[5] & funct7_5) ? ALU_SUB : ALU_ADD;
      funct3 == 3'b010: alu_dec = ALU_SLT;
      funct3 == 3'b110: alu_dec = ALU_OR;
      funct3 == 3'b111: alu_dec = ALU_AND;
      default:          f3_ok   = 1'b0;
    endcase
  end

  assign br_ok = (funct3 == 3'b000) | (funct3 == 3'b001);

  always_comb begin
    state_n = state;
    case (state)
      FETCH:    if (mem_ready) state_n = DECODE;
      DECODE: begin
        unique case (1'b1)
          op == 7'b0000011: state_n = MEMADR;
          op == 7'b0100011: state_n = MEMADR;
          op == 7'b0110011: state_n = EXECR;
          op == 7'b0010011: state_n = EXECI;
          op == 7'b1100011: state_n = br_ok ? BRANCH : TRAP;
          default:          state_n = TRAP;
        endcase
      end
      MEMADR:   state_n = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_n = MEMWB;
      MEMWB:    state_n = FETCH;
      MEMWRITE: if (mem_ready) state_n = FETCH;
      EXECR:    state_n = f3_ok ? ALUWB : TRAP;
      EXECI:    state_n = f3_ok ? ALUWB : TRAP;
      ALUWB:    state_n = FETCH;
      BRANCH:   state_n = FETCH;
      TRAP:     state_n = TRAP;
      default:  state_n = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_n;
  end

  // Everything is held low while rst is high, including mem_req.
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    ALUctrl    = ALU_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          mem_req   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          ImmSrc  = 2'b10;
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = op[5] ? 2'b01 : 2'b00;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        MEMWB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWRITE: begin
          mem_req    = 1'b1;
          MemWrite   = 1'b1;
          AdrSrc     = 1'b1;
          instr_done = mem_ready;
        end
        EXECR: begin
          ALUSrcA = 2'b10;
          ALUctrl = alu_dec;
        end
        EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUctrl = alu_dec;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUctrl    = ALU_SUB;
          instr_done = 1'b1;
          PCWrite    = (funct3 == 3'b000 & EQ)
                     | (funct3 == 3'b001 & !EQ);
        end
        TRAP:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors
// checked against hand-derived expectations for each instruction class.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       EQ;
  logic       mem_ready;
  logic       mem_req;
  logic       MemWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       RegWrite;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic [2:0] ALUctrl;
  logic       instr_done;
  logic       illegal;

  int n_cmp;
  int n_fail;

  multicycle_control dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3),
    .funct7_5(funct7_5), .EQ(EQ), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUctrl(ALUctrl), .instr_done(instr_done),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // req,MW,Adr,IR,PCW,RW,SrcA,SrcB,Res,Imm,ALU,done,ill
  logic [18:0] outv;
  assign outv = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite,
                 RegWrite, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
                 ALUctrl, instr_done, illegal};

  localparam logic [18:0] ZERO  = '0;
  localparam logic [18:0] F_R1  = {5'b10011, 1'b0, 2'b00, 2'b10,
                                   2'b10, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] F_R0  = {5'b10000, 1'b0, 2'b00, 2'b10,
                                   2'b10, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] DEC   = {5'b00000, 1'b0, 2'b01, 2'b01,
                                   2'b00, 2'b10, 3'b000, 2'b00};
  localparam logic [18:0] EXR_A = {5'b00000, 1'b0, 2'b10, 2'b00,
                                   2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] EXR_S = {5'b00000, 1'b0, 2'b10, 2'b00,
                                   2'b00, 2'b00, 3'b001, 2'b00};
  localparam logic [18:0] EXI_O = {5'b00000, 1'b0, 2'b10, 2'b01,
                                   2'b00, 2'b00, 3'b011, 2'b00};
  localparam logic [18:0] ALUWB = {5'b00000, 1'b1, 2'b00, 2'b00,
                                   2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [18:0] MA_LW = {5'b00000, 1'b0, 2'b10, 2'b01,
                                   2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] MA_SW = {5'b00000, 1'b0, 2'b10, 2'b01,
                                   2'b00, 2'b01, 3'b000, 2'b00};
  localparam logic [18:0] MRD   = {5'b10100, 1'b0, 2'b00, 2'b00,
                                   2'b00, 2'b00, 3'b000, 2'b00};
  localparam logic [18:0] MWB   = {5'b00000, 1'b1, 2'b00, 2'b00,
                                   2'b01, 2'b00, 3'b000, 2'b10};
  localparam logic [18:0] MWR1  = {5'b11100, 1'b0, 2'b00, 2'b00,
                                   2'b00, 2'b00, 3'b000, 2'b10};
  localparam logic [18:0] BR_T  = {5'b00001, 1'b0, 2'b10, 2'b00,
                                   2'b00, 2'b00, 3'b001, 2'b10};
  localparam logic [18:0] BR_N  = {5'b00000, 1'b0, 2'b10, 2'b00,
                                   2'b00, 2'b00, 3'b001, 2'b10};
  localparam logic [18:0] TRAPV = {5'b00000, 1'b0, 2'b00, 2'b00,
                                   2'b00, 2'b00, 3'b000, 2'b01};

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (outv !== ZERO) begin
        n_fail++;
        $display("FAIL reset cyc %0d: got %h want %h",
                 i, outv, ZERO);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype(input logic f7);
    logic [18:0] ev [4];
    ev = '{F_R1, DEC, (f7 ? EXR_S : EXR_A), ALUWB};
    op = 7'b0110011; funct3 = 3'b000; funct7_5 = f7;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (outv !== ev[i]) begin
        n_fail++;
        $display("FAIL rtype f7=%0d cyc %0d: got %h want %h",
                 f7, i, outv, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_itype_or();
    logic [18:0] ev [4];
    ev = '{F_R1, DEC, EXI_O, ALUWB};
    op = 7'b0010011; funct3 = 3'b110; funct7_5 = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (outv !== ev[i]) begin
        n_fail++;
        $display("FAIL itype_or cyc %0d: got %h want %h",
                 i, outv, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw_wait();
    logic [18:0] ev [10];
    logic        rv [10];
    ev = '{F_R0, F_R0, F_R1, DEC, MA_LW,
           MRD, MRD, MRD, MRD, MWB};
    rv = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
    op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_ready = rv[i];
      #1;
      n_cmp++;
      if (outv !== ev[i]) begin
        n_fail++;
        $display("FAIL lw_wait cyc %0d: got %h want %h",
                 i, outv, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [18:0] ev [4];
    ev = '{F_R1, DEC, MA_SW, MWR1};
    op = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (outv !== ev[i]) begin
        n_fail++;
        $display("FAIL sw cyc %0d: got %h want %h",
                 i, outv, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch(input logic [2:0] f3,
                             input logic eq,
                             input logic taken);
    logic [18:0] ev [3];
    ev = '{F_R1, DEC, (taken ? BR_T : BR_N)};
    op = 7'b1100011; funct3 = f3; funct7_5 = 1'b0;
    EQ = eq; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (outv !== ev[i]) begin
        n_fail++;
        $display("FAIL branch f3=%0d eq=%0d cyc %0d: got %h want %h",
                 f3, eq, i, outv, ev[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_access();
    logic [18:0] ev [6];
    logic        rv [6];
    logic        sv [6];
    ev = '{F_R1, DEC, MA_LW, MRD, ZERO, F_R0};
    rv = '{1, 1, 1, 0, 0, 0};
    sv = '{0, 0, 0, 0, 1, 0};
    op = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rv[i];
      rst = sv[i];
      #1;
      n_cmp++;
      if (outv !== ev[i]) begin
        n_fail++;
        $display("FAIL mid_reset cyc %0d: got %h want %h",
                 i, outv, ev[i]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_bad_funct3();
    logic [18:0] ev [5];
    logic        sv [5];
    ev = '{F_R1, DEC, EXR_A, TRAPV, ZERO};
    sv = '{0, 0, 0, 0, 1};
    op = 7'b0110011; funct3 = 3'b001; funct7_5 = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rst = sv[i];
      #1;
      n_cmp++;
      if (outv !== ev[i]) begin
        n_fail++;
        $display("FAIL bad_funct3 cyc %0d: got %h want %h",
                 i, outv, ev[i]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_trap();
    op = 7'b1111111; funct3 = 3'b000; funct7_5 = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (outv !== F_R1) begin
      n_fail++;
      $display("FAIL trap fetch: got %h want %h", outv, F_R1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (outv !== DEC) begin
      n_fail++;
      $display("FAIL trap decode: got %h want %h", outv, DEC);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      op = 7'b0110011;
      #1;
      n_cmp++;
      if (outv !== TRAPV) begin
        n_fail++;
        $display("FAIL trap hold cyc %0d: got %h want %h",
                 i, outv, TRAPV);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (outv !== ZERO) begin
      n_fail++;
      $display("FAIL trap in_reset: got %h want %h", outv, ZERO);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (outv !== F_R1) begin
      n_fail++;
      $display("FAIL trap released: got %h want %h", outv, F_R1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    op = '0;
    funct3 = '0;
    funct7_5 = 1'b0;
    EQ = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype(1'b0);
    test_rtype(1'b1);
    test_itype_or();
    test_lw_wait();
    test_sw();
    test_branch(3'b000, 1'b1, 1'b1);
    test_branch(3'b000, 1'b0, 1'b0);
    test_branch(3'b001, 1'b0, 1'b1);
    test_branch(3'b001, 1'b1, 1'b0);
    test_reset_mid_access();
    test_rtype(1'b0);
    test_bad_funct3();
    test_sw();
    test_trap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Finite-state sequencer for the multi-cycle RV32I datapath variant. It steps each instruction through fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified instruction/data memory port. It drives every datapath mux select and write enable, and stalls on a request/ready memory handshake. It covers the same instruction subset as the single-cycle control path: R-type, I-type ALU, lw, sw, beq, bne.

## Interface
No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  7  opcode from instruction register; valid from DECODE onward
- funct3  in  3  instruction bits [14:12]
- funct7_5  in  1  instruction bit 30
- EQ  in  1  ALU zero flag (rs1 == rs2 during BRANCH)
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  access is a store (only with mem_req)
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load instruction register; also latches OldPC
- PCWrite  out  1  load PC from result bus
- RegWrite  out  1  register file write
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
- ResultSrc  out  2  00 = ALUOut, 01 = memory data, 10 = ALU result (bypass)
- ImmSrc  out  2  00 = I, 01 = S, 10 = B
- ALUctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  sticky: unsupported encoding decoded

## Operation
States are FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH and TRAP. Any output not listed for a state is 0; ALUctrl defaults to add.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCWrite pulse only in the cycle mem_ready=1, and the state then moves to DECODE. While mem_ready=0 the state holds.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=10 (computes the branch target into ALUOut).
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - any other opcode → TRAP
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc = 00 for lw, 01 for sw. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: mem_req=1, AdrSrc=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Goes to FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Holds until mem_ready, then pulses instr_done and goes to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUctrl decoded from funct3/funct7_5. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=00, ALUctrl decoded from funct3. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Goes to FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUctrl=sub, ResultSrc=00, instr_done=1. Goes to FETCH.
  - PCWrite = (funct3==000 & EQ) | (funct3==001 & !EQ).
- ALU decode:
  - funct3 000 → add, except sub when op[5] & funct7_5 (R-type only)
  - 010 → slt
  - 110 → or
  - 111 → and
  - any other funct3 in EXECR/EXECI, or a branch funct3 other than 000/001 → TRAP instead of ALUWB/BRANCH writeback. No RegWrite or PCWrite occurs.
- TRAP: illegal=1, all enables 0, no exit except rst.

## Timing
- Outputs are Moore-decoded from state. The exceptions are the FETCH IRWrite/PCWrite and the BRANCH PCWrite, which also depend on the current-cycle inputs.
- Latency with mem_ready tied high:
  - beq/bne: 3 cycles
  - R-type, I-type ALU, sw: 4 cycles
  - lw: 5 cycles
  - Each wait cycle on a memory access adds 1.
- mem_req stays asserted, with a stable address select, until the cycle mem_ready=1 is sampled. mem_ready is ignored in all other states.
- Reset: while rst=1, every output is forced to 0 (including mem_req). State becomes FETCH and illegal clears at the clock edge. mem_req first rises in the cycle after rst deasserts.
- Reset mid-access (e.g. in MEMREAD with mem_ready=0): the access is abandoned, no write enable fires, and the block restarts in FETCH.
- instr_done never coincides with IRWrite. Exactly one instr_done is issued per retired instruction; none is issued in TRAP.

## Test plan
- Reset release, mem_ready=1, R-type add (op 0110011, funct3 000, funct7_5=0): states FETCH, DECODE, EXECR, ALUWB. RegWrite=1 in cycle 4 with ALUctrl=000 in EXECR. funct7_5=1 gives ALUctrl=001.
- lw with mem_ready held low 2 cycles in FETCH and 3 in MEMREAD: mem_req held steady with AdrSrc 0 then 1. RegWrite with ResultSrc=01 in cycle 10 after reset release.
- sw: MEMWRITE asserts mem_req=1, MemWrite=1, AdrSrc=1, ImmSrc=01 in MEMADR. RegWrite never asserts. 4 cycles.
- beq with EQ=1 → PCWrite=1 in BRANCH. beq with EQ=0 → 0. bne with EQ=0 → 1. Each takes 3 cycles.
- op 1111111 → TRAP after DECODE, illegal=1 sticky for 20 cycles, no enables. rst pulse → FETCH, illegal=0.
- rst asserted in MEMREAD while mem_ready=0 → all outputs 0 during reset. The next cycle after release is FETCH with mem_req=1 and AdrSrc=0.
